// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - State type, default reg-bus structs and round-robin pick function for reg_rr_arbiter
package reg_arb_pkg;

    localparam int unsigned MaxReq  = 32;
    localparam int unsigned MaxIdxW = $clog2(MaxReq);

    typedef enum logic {
        Idle = 1'b0,
        Busy = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    // First set bit of valid[num-1:0] found searching ptr, ptr+1, ... and wrapping at num.
    function automatic logic [31:0] rr_pick(
        input logic [MaxReq-1:0] valid,
        input logic [31:0]       ptr,
        input logic [31:0]       num
    );
        logic [31:0] idx;
        logic [31:0] result;
        logic        found;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < MaxReq; i++) begin
            idx = ptr + 32'(i);
            if (idx >= num) begin
                idx = idx - num;
            end
            if (!found && (32'(i) < num) && valid[idx[MaxIdxW-1:0]]) begin
                found  = 1'b1;
                result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_arb_rr_ptr.sv
// rtl/reg_arb_rr_ptr.sv - Round-robin priority pointer; moves to the slot after the finished grant
module reg_arb_rr_ptr #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            adv_i,
    input  logic [IdxW-1:0] gnt_i,
    output logic [IdxW-1:0] ptr_o
);

    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] w_ptr_next;

    always_comb begin
        w_ptr_next = r_ptr;
        if (adv_i) begin
            if (gnt_i == IdxW'(NumReq - 1)) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = gnt_i + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/reg_rr_arbiter.sv
// rtl/reg_rr_arbiter.sv - Round-robin arbiter sharing one reg-bus slave among NumReq masters
// Optional Busy watchdog enabled by REG_ARB_TIMEOUT_EN.
module reg_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned  NumReq        = 4,
    parameter type          req_t         = reg_req_t,
    parameter type          rsp_t         = reg_rsp_t,
    parameter int unsigned  TimeoutCycles = 1024,
    localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  req_t            req_i [NumReq],
    output rsp_t            rsp_o [NumReq],
    output req_t            req_o,
    input  rsp_t            rsp_i,
    output logic            busy_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    if ((NumReq < 1) || (NumReq > MaxReq) || (TimeoutCycles < 2)) begin : g_bad_param
        $error("reg_rr_arbiter: NumReq must be 1..%0d and TimeoutCycles >= 2", MaxReq);
    end

    state_e            r_state;
    state_e            w_state_d;
    logic [IdxW-1:0]   r_gnt_q;
    logic [IdxW-1:0]   w_rr_ptr;
    logic [IdxW-1:0]   w_winner;
    logic [NumReq-1:0] w_valid;
    logic [31:0]       w_pick;
    logic              w_any_valid;
    logic              w_done;
    logic              w_tmo_hit;

    always_comb begin
        w_valid = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_valid[k] = req_i[k].valid;
        end
    end

    assign w_any_valid = |w_valid;
    assign w_pick      = rr_pick(MaxReq'(w_valid), 32'(w_rr_ptr), 32'(NumReq));
    assign w_winner    = IdxW'(w_pick);

`ifdef REG_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    logic [TmoW-1:0] r_tmo_cnt;

    // Held at zero outside Busy so every grant starts a fresh count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state != Busy) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
        end
    end

    assign w_tmo_hit = (r_state == Busy) && (r_tmo_cnt == TmoW'(TimeoutCycles - 1)) && !rsp_i.ready;
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_done    = 1'b0;
        req_o     = '0;
        for (int k = 0; k < NumReq; k++) begin
            rsp_o[k] = '0;
        end
        case (r_state)
            Idle: begin
                if (w_any_valid) begin
                    w_state_d = Busy;
                end
            end
            Busy: begin
                req_o          = req_i[r_gnt_q];
                rsp_o[r_gnt_q] = rsp_i;
                // A real slave response always beats the watchdog in the same cycle.
                if (rsp_i.ready) begin
                    w_done    = 1'b1;
                    w_state_d = Idle;
                end else if (w_tmo_hit) begin
                    req_o.valid          = 1'b0;
                    rsp_o[r_gnt_q].rdata = '0;
                    rsp_o[r_gnt_q].error = 1'b1;
                    rsp_o[r_gnt_q].ready = 1'b1;
                    w_done               = 1'b1;
                    w_state_d            = Idle;
                end else if (!req_i[r_gnt_q].valid) begin
                    w_state_d = Idle;
                end
            end
            default: w_state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= Idle;
            r_gnt_q <= '0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == Idle) && w_any_valid) begin
                r_gnt_q <= w_winner;
            end
        end
    end

    reg_arb_rr_ptr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_ptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adv_i  (w_done),
        .gnt_i  (r_gnt_q),
        .ptr_o  (w_rr_ptr)
    );

    assign busy_o    = (r_state == Busy);
    assign gnt_idx_o = r_gnt_q;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb/tb_reg_rr_arbiter.sv - Self-checking bench for reg_rr_arbiter (vector table plus response scoreboard)
module tb_reg_rr_arbiter;
    import reg_arb_pkg::*;

    logic       clk;
    logic       rst_i;
    reg_req_t   req_i [4];
    reg_rsp_t   rsp_o [4];
    reg_req_t   req_o;
    reg_rsp_t   rsp_i;
    logic       busy_o;
    logic [1:0] gnt_idx_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  mask;
        int          exp_gnt;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs [10];

    reg_rr_arbiter #(
        .NumReq        (4),
        .TimeoutCycles (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .rsp_o     (rsp_o),
        .req_o     (req_o),
        .rsp_i     (rsp_i),
        .busy_o    (busy_o),
        .gnt_idx_o (gnt_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic reg_req_t mk_req(input int k, input logic v);
        reg_req_t r;
        r.addr  = 32'h100 + 32'(k * 4);
        r.write = ((k % 2) == 1);
        r.wdata = 32'hA000_0000 + 32'(k);
        r.wstrb = 4'hF;
        r.valid = v;
        return r;
    endfunction

    task automatic drive_mask(input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            req_i[k] = mk_req(k, mask[k]);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] rdata, input logic err);
        sb_t e;
        e.idx   = idx;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // One transaction, slave ready in the first Busy cycle; entered and left in an Idle cycle.
    task automatic run_txn(input logic [3:0] mask, input int exp_gnt, input logic [31:0] rdata, input string name);
        drive_mask(mask);
        rsp_i = '0;
        #2;
        chk({name, "_idle_busy"}, 64'(busy_o), 64'(0));
        chk({name, "_idle_valid"}, 64'(req_o.valid), 64'(0));
        tick();
        chk({name, "_gnt"}, 64'(gnt_idx_o), 64'(exp_gnt));
        chk({name, "_busy"}, 64'(busy_o), 64'(1));
        chk({name, "_req_valid"}, 64'(req_o.valid), 64'(1));
        chk({name, "_req_addr"}, 64'(req_o.addr), 64'(32'h100 + 32'(exp_gnt * 4)));
        chk({name, "_req_wdata"}, 64'(req_o.wdata), 64'(32'hA000_0000 + 32'(exp_gnt)));
        rsp_i.rdata = rdata;
        rsp_i.ready = 1'b1;
        push_exp(exp_gnt, rdata, 1'b0);
        tick();
        drive_mask('0);
        rsp_i = '0;
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (rsp_o[k].ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected: m%0d got ready=1, required no response", k);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        chk("sb_idx", 64'(k), 64'(e.idx));
                        chk("sb_rdata", 64'(rsp_o[k].rdata), 64'(e.rdata));
                        chk("sb_error", 64'(rsp_o[k].error), 64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cont_exp [5];
        int grants;
        logic prev_busy;

        vecs[0] = '{4'b0001, 0, 32'h0000_1000};
        vecs[1] = '{4'b0001, 0, 32'h0000_1001};
        vecs[2] = '{4'b1111, 1, 32'h0000_1002};
        vecs[3] = '{4'b1001, 3, 32'h0000_1003};
        vecs[4] = '{4'b1010, 1, 32'h0000_1004};
        vecs[5] = '{4'b0011, 0, 32'h0000_1005};
        vecs[6] = '{4'b0100, 2, 32'h0000_1006};
        vecs[7] = '{4'b0110, 1, 32'h0000_1007};
        vecs[8] = '{4'b1100, 2, 32'h0000_1008};
        vecs[9] = '{4'b1111, 3, 32'h0000_1009};
        cont_exp = '{0, 1, 2, 3, 0};

        // Reset held with every master requesting and the slave claiming ready.
        rst_i = 1'b1;
        drive_mask(4'hF);
        rsp_i = '{rdata: 32'hFFFF_FFFF, error: 1'b0, ready: 1'b1};
        for (int c = 0; c < 3; c++) begin
            tick();
            #2;
            chk("rst_busy", 64'(busy_o), 64'(0));
            chk("rst_req_valid", 64'(req_o.valid), 64'(0));
            chk("rst_gnt_idx", 64'(gnt_idx_o), 64'(0));
            for (int k = 0; k < 4; k++) begin
                chk("rst_rsp_ready", 64'(rsp_o[k].ready), 64'(0));
            end
        end
        tick();
        rst_i = 1'b0;
        drive_mask('0);
        rsp_i = '0;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].mask, vecs[i].exp_gnt, vecs[i].rdata, "tbl");
        end

        // m2 write to 0x10, slave ready in the third Busy cycle.
        drive_mask(4'b0100);
        req_i[2].addr  = 32'h10;
        req_i[2].write = 1'b1;
        rsp_i = '0;
        #2;
        chk("single_lat0_valid", 64'(req_o.valid), 64'(0));
        tick();
        chk("single_req_valid", 64'(req_o.valid), 64'(1));
        chk("single_req_addr", 64'(req_o.addr), 64'(32'h10));
        chk("single_req_write", 64'(req_o.write), 64'(1));
        chk("single_gnt", 64'(gnt_idx_o), 64'(2));
        tick();
        #2;
        chk("single_wait_busy", 64'(busy_o), 64'(1));
        chk("single_wait_ready", 64'(rsp_o[2].ready), 64'(0));
        tick();
        rsp_i.rdata = 32'h77;
        rsp_i.ready = 1'b1;
        push_exp(2, 32'h77, 1'b0);
        #2;
        chk("single_rsp_ready", 64'(rsp_o[2].ready), 64'(1));
        tick();
        drive_mask('0);
        rsp_i = '0;
        #2;
        chk("single_done_busy", 64'(busy_o), 64'(0));
        chk("single_done_valid", 64'(req_o.valid), 64'(0));
        tick();
        run_txn(4'b1111, 3, 32'h0000_2003, "single_next");

        // All masters hold valid; slave answers every Busy cycle.
        drive_mask(4'hF);
        rsp_i = '0;
        grants = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 30 && grants < 5; c++) begin
            tick();
            if (busy_o) begin
                chk("cont_idle_gap", 64'(prev_busy), 64'(0));
                chk("cont_order", 64'(gnt_idx_o), 64'(cont_exp[grants]));
                rsp_i.rdata = 32'h5000 + 32'(grants);
                rsp_i.ready = 1'b1;
                push_exp(cont_exp[grants], 32'h5000 + 32'(grants), 1'b0);
                grants++;
            end else begin
                rsp_i = '0;
            end
            prev_busy = busy_o;
        end
        chk("cont_grant_count", 64'(grants), 64'(5));
        tick();
        drive_mask('0);
        rsp_i = '0;

        // Response reaches the winner only.
        drive_mask(4'b1011);
        tick();
        chk("iso_gnt", 64'(gnt_idx_o), 64'(1));
        rsp_i.rdata = 32'hCAFE;
        rsp_i.ready = 1'b1;
        push_exp(1, 32'hCAFE, 1'b0);
        #2;
        chk("iso_m1_rdata", 64'(rsp_o[1].rdata), 64'(32'hCAFE));
        chk("iso_m1_ready", 64'(rsp_o[1].ready), 64'(1));
        chk("iso_m0_zero", 64'(rsp_o[0]), 64'(0));
        chk("iso_m2_zero", 64'(rsp_o[2]), 64'(0));
        chk("iso_m3_zero", 64'(rsp_o[3]), 64'(0));
        tick();
        drive_mask('0);
        rsp_i = '0;

        // Master drops valid mid-Busy: abandon without moving the pointer.
        drive_mask(4'b0100);
        tick();
        chk("drop_gnt", 64'(gnt_idx_o), 64'(2));
        tick();
        drive_mask('0);
        #2;
        chk("drop_no_ready", 64'(rsp_o[2].ready), 64'(0));
        tick();
        chk("drop_idle", 64'(busy_o), 64'(0));
        run_txn(4'b1111, 2, 32'h0000_3002, "drop_next");

`ifdef REG_ARB_TIMEOUT_EN
        drive_mask(4'b1000);
        rsp_i = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                chk("tmo_gnt", 64'(gnt_idx_o), 64'(3));
            end
            if (c < 8) begin
                #2;
                chk("tmo_wait_busy", 64'(busy_o), 64'(1));
                chk("tmo_wait_ready", 64'(rsp_o[3].ready), 64'(0));
            end else begin
                push_exp(3, 32'h0, 1'b1);
                #2;
                chk("tmo_hit_ready", 64'(rsp_o[3].ready), 64'(1));
                chk("tmo_hit_error", 64'(rsp_o[3].error), 64'(1));
                chk("tmo_hit_req_valid", 64'(req_o.valid), 64'(0));
            end
        end
        tick();
        drive_mask('0);
        #2;
        chk("tmo_after_idle", 64'(busy_o), 64'(0));
        tick();

        drive_mask(4'b1001);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                chk("tmo_ready_gnt", 64'(gnt_idx_o), 64'(0));
            end
            if (c == 8) begin
                rsp_i.rdata = 32'h1234;
                rsp_i.ready = 1'b1;
                push_exp(0, 32'h1234, 1'b0);
                #2;
                chk("tmo_ready_rsp", 64'(rsp_o[0].ready), 64'(1));
                chk("tmo_ready_error", 64'(rsp_o[0].error), 64'(0));
                chk("tmo_ready_req_valid", 64'(req_o.valid), 64'(1));
            end
        end
        tick();
        drive_mask('0);
        rsp_i = '0;
`endif

        // Async reset between edges while Busy.
        drive_mask(4'b1010);
        tick();
        chk("areset_pre_busy", 64'(busy_o), 64'(1));
        #2;
        rst_i = 1'b1;
        rsp_i = '{rdata: 32'hDEAD, error: 1'b0, ready: 1'b1};
        #1;
        chk("areset_busy", 64'(busy_o), 64'(0));
        chk("areset_req_valid", 64'(req_o.valid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            chk("areset_rsp_zero", 64'(rsp_o[k]), 64'(0));
        end
        tick();
        rst_i = 1'b0;
        rsp_i = '0;
        #2;
        chk("areset_release_idle", 64'(busy_o), 64'(0));
        tick();
        chk("areset_first_gnt", 64'(gnt_idx_o), 64'(1));
        rsp_i.rdata = 32'h4001;
        rsp_i.ready = 1'b1;
        push_exp(1, 32'h4001, 1'b0);
        tick();
        drive_mask('0);
        rsp_i = '0;

        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
